// File: rtl/flapjack_pkg.sv
// rtl/flapjack_pkg.sv - shared widths and stage-A record for the flapjack operand-fetch slice
package flapjack_pkg;

    // Build configuration of the slice; the regfile is built with the same values.
    localparam int FJ_WIDTH = 16;
    localparam int FJ_COUNT = 8;
    localparam int FJ_OPW   = 8;
    localparam int FJ_IDXW  = $clog2(FJ_COUNT);

    typedef logic [FJ_OPW-1:0]  op_t;
    typedef logic [FJ_IDXW-1:0] idx_t;

    // Decoded op parked in stage A while its operands are read.
    typedef struct packed {
        op_t  op;
        idx_t rs1;
        idx_t rs2;
        idx_t rd;
        logic wr;
    } stage_a_t;

    // True when a writeback this cycle targets the given register.
    function automatic logic wb_hit(input logic wb_valid, input idx_t wb_index, input idx_t idx);
        return wb_valid && (wb_index == idx);
    endfunction

endpackage

// File: rtl/flapjack_operand_fetch_if.sv
// rtl/flapjack_operand_fetch_if.sv - decode, regfile, writeback and execute signals of the operand-fetch stage
interface flapjack_operand_fetch_if #(
    parameter int WIDTH = 16,
    parameter int COUNT = 8,
    parameter int OPW   = 8
);
    localparam int IDXW = $clog2(COUNT);

    // decode side
    logic             dec_valid;
    logic             dec_ready;
    logic [OPW-1:0]   dec_op;
    logic [IDXW-1:0]  dec_rs1;
    logic [IDXW-1:0]  dec_rs2;
    logic [IDXW-1:0]  dec_rd;
    logic             dec_wr;

    // regfile read ports
    logic [WIDTH-1:0] rf_read_index1;
    logic [WIDTH-1:0] rf_read_index2;
    logic [WIDTH-1:0] rf_read_value1;
    logic [WIDTH-1:0] rf_read_value2;

    // writeback broadcast
    logic             wb_valid;
    logic [IDXW-1:0]  wb_index;
    logic [WIDTH-1:0] wb_value;

    // execute side
    logic             ex_valid;
    logic             ex_ready;
    logic [OPW-1:0]   ex_op;
    logic [WIDTH-1:0] ex_a;
    logic [WIDTH-1:0] ex_b;
    logic [IDXW-1:0]  ex_rd;
    logic             ex_wr;

    // Environment around the stage: decode, regfile, writeback and execute.
    modport master (
        output dec_valid, dec_op, dec_rs1, dec_rs2, dec_rd, dec_wr,
        input  dec_ready,
        input  rf_read_index1, rf_read_index2,
        output rf_read_value1, rf_read_value2,
        output wb_valid, wb_index, wb_value,
        input  ex_valid, ex_op, ex_a, ex_b, ex_rd, ex_wr,
        output ex_ready
    );

    // The operand-fetch stage itself.
    modport slave (
        input  dec_valid, dec_op, dec_rs1, dec_rs2, dec_rd, dec_wr,
        output dec_ready,
        output rf_read_index1, rf_read_index2,
        input  rf_read_value1, rf_read_value2,
        input  wb_valid, wb_index, wb_value,
        output ex_valid, ex_op, ex_a, ex_b, ex_rd, ex_wr,
        input  ex_ready
    );

endinterface

// File: rtl/flapjack_scoreboard.sv
// rtl/flapjack_scoreboard.sv - pending-write scoreboard with three hazard lookups
module flapjack_scoreboard #(
    parameter int  COUNT = 8,
    localparam int IDXW  = $clog2(COUNT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set_en_i,
    input  logic [IDXW-1:0] set_idx_i,
    input  logic            clr_en_i,
    input  logic [IDXW-1:0] clr_idx_i,
    input  logic [IDXW-1:0] look1_idx_i,
    input  logic [IDXW-1:0] look2_idx_i,
    input  logic [IDXW-1:0] look3_idx_i,
    output logic            busy1_o,
    output logic            busy2_o,
    output logic            busy3_o
);

    logic [COUNT-1:0] pending_q;
    logic [COUNT-1:0] pending_d;

    // Apply the clear first so an issue to the same register on the same edge keeps the bit set.
    always_comb begin
        pending_d = pending_q;
        if (clr_en_i) begin
            pending_d[clr_idx_i] = 1'b0;
        end
        if (set_en_i) begin
            pending_d[set_idx_i] = 1'b1;
        end
    end

    // Pending-bit register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // A writeback landing this cycle resolves the lookup, its value is bypassed by the caller.
    always_comb begin
        busy1_o = pending_q[look1_idx_i] && !(clr_en_i && (clr_idx_i == look1_idx_i));
        busy2_o = pending_q[look2_idx_i] && !(clr_en_i && (clr_idx_i == look2_idx_i));
        busy3_o = pending_q[look3_idx_i] && !(clr_en_i && (clr_idx_i == look3_idx_i));
    end

endmodule

// File: rtl/flapjack_operand_fetch.sv
// rtl/flapjack_operand_fetch.sv - operand-fetch stage: regfile read, writeback bypass, hazard stall, EX register
module flapjack_operand_fetch
    import flapjack_pkg::*;
#(
    parameter int WIDTH = FJ_WIDTH,
    parameter int COUNT = FJ_COUNT,
    parameter int OPW   = FJ_OPW
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    flapjack_operand_fetch_if.slave bus
);

    localparam int IDXW = $clog2(COUNT);

    // stage A
    stage_a_t         a_q, a_d;
    logic             a_valid_q, a_valid_d;

    // EX output register
    logic             ex_valid_q, ex_valid_d;
    logic [OPW-1:0]   ex_op_q, ex_op_d;
    logic [WIDTH-1:0] ex_a_q, ex_a_d;
    logic [WIDTH-1:0] ex_b_q, ex_b_d;
    idx_t             ex_rd_q, ex_rd_d;
    logic             ex_wr_q, ex_wr_d;

    // writebacks that hit the index presented to the regfile on the previous edge
    logic             fwd1_q, fwd1_d;
    logic             fwd2_q, fwd2_d;
    logic [WIDTH-1:0] fwdval1_q, fwdval1_d;
    logic [WIDTH-1:0] fwdval2_q, fwdval2_d;

    logic             haz_rs1, haz_rs2, haz_rd;
    logic             hazard;
    logic             a_adv;
    logic             dec_ready;
    logic             dec_accept;
    idx_t             rd_idx1, rd_idx2;
    logic [WIDTH-1:0] opnd1, opnd2;

    flapjack_scoreboard #(.COUNT(COUNT)) u_sb (
        .clk         (clk),
        .rst         (rst),
        .set_en_i    (a_adv && a_q.wr && !flush),
        .set_idx_i   (a_q.rd),
        .clr_en_i    (bus.wb_valid),
        .clr_idx_i   (bus.wb_index),
        .look1_idx_i (a_q.rs1),
        .look2_idx_i (a_q.rs2),
        .look3_idx_i (a_q.rd),
        .busy1_o     (haz_rs1),
        .busy2_o     (haz_rs2),
        .busy3_o     (haz_rd)
    );

    // Handshake: A advances when its sources and destination are clear and EX has room.
    always_comb begin
        hazard     = haz_rs1 || haz_rs2 || (a_q.wr && haz_rd);
        a_adv      = a_valid_q && !hazard && (!ex_valid_q || bus.ex_ready);
        dec_ready  = !a_valid_q || a_adv;
        dec_accept = bus.dec_valid && dec_ready;
    end

    // A stalled op keeps its own indices on the regfile so the read is refreshed every cycle.
    always_comb begin
        rd_idx1 = (a_valid_q && !a_adv) ? a_q.rs1 : bus.dec_rs1;
        rd_idx2 = (a_valid_q && !a_adv) ? a_q.rs2 : bus.dec_rs2;
        bus.rf_read_index1 = {{(WIDTH-IDXW){1'b0}}, rd_idx1};
        bus.rf_read_index2 = {{(WIDTH-IDXW){1'b0}}, rd_idx2};
    end

    // The regfile returns the pre-write value when the write lands on the read edge; remember it here.
    always_comb begin
        fwd1_d    = wb_hit(bus.wb_valid, bus.wb_index, rd_idx1);
        fwd2_d    = wb_hit(bus.wb_valid, bus.wb_index, rd_idx2);
        fwdval1_d = bus.wb_value;
        fwdval2_d = bus.wb_value;
    end

    // Operand select: live writeback, then captured same-edge writeback, then regfile data.
    always_comb begin
        if (wb_hit(bus.wb_valid, bus.wb_index, a_q.rs1)) begin
            opnd1 = bus.wb_value;
        end else if (fwd1_q) begin
            opnd1 = fwdval1_q;
        end else begin
            opnd1 = bus.rf_read_value1;
        end
        if (wb_hit(bus.wb_valid, bus.wb_index, a_q.rs2)) begin
            opnd2 = bus.wb_value;
        end else if (fwd2_q) begin
            opnd2 = fwdval2_q;
        end else begin
            opnd2 = bus.rf_read_value2;
        end
    end

    // Stage A next state: flush empties it, an accept refills it, an advance alone drains it.
    always_comb begin
        a_d       = a_q;
        a_valid_d = a_valid_q;
        if (flush) begin
            a_valid_d = 1'b0;
        end else if (dec_accept) begin
            a_d.op    = bus.dec_op;
            a_d.rs1   = bus.dec_rs1;
            a_d.rs2   = bus.dec_rs2;
            a_d.rd    = bus.dec_rd;
            a_d.wr    = bus.dec_wr;
            a_valid_d = 1'b1;
        end else if (a_adv) begin
            a_valid_d = 1'b0;
        end
    end

    // EX next state: load on advance, drop when consumed, otherwise hold everything stable.
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_op_d    = ex_op_q;
        ex_a_d     = ex_a_q;
        ex_b_d     = ex_b_q;
        ex_rd_d    = ex_rd_q;
        ex_wr_d    = ex_wr_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (a_adv) begin
            ex_valid_d = 1'b1;
            ex_op_d    = a_q.op;
            ex_a_d     = opnd1;
            ex_b_d     = opnd2;
            ex_rd_d    = a_q.rd;
            ex_wr_d    = a_q.wr;
        end else if (bus.ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    // Pipeline registers; reset wins over flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= '0;
            a_valid_q  <= 1'b0;
            ex_valid_q <= 1'b0;
            ex_op_q    <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_rd_q    <= '0;
            ex_wr_q    <= 1'b0;
            fwd1_q     <= 1'b0;
            fwd2_q     <= 1'b0;
            fwdval1_q  <= '0;
            fwdval2_q  <= '0;
        end else begin
            a_q        <= a_d;
            a_valid_q  <= a_valid_d;
            ex_valid_q <= ex_valid_d;
            ex_op_q    <= ex_op_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            ex_rd_q    <= ex_rd_d;
            ex_wr_q    <= ex_wr_d;
            fwd1_q     <= fwd1_d;
            fwd2_q     <= fwd2_d;
            fwdval1_q  <= fwdval1_d;
            fwdval2_q  <= fwdval2_d;
        end
    end

    // Output drive.
    always_comb begin
        bus.dec_ready = dec_ready;
        bus.ex_valid  = ex_valid_q;
        bus.ex_op     = ex_op_q;
        bus.ex_a      = ex_a_q;
        bus.ex_b      = ex_b_q;
        bus.ex_rd     = ex_rd_q;
        bus.ex_wr     = ex_wr_q;
    end

endmodule
